sfx_tone_gen: RTL and testbench

Sound-effect generator for the game's audio pin. It takes one-cycle game events (jump, score milestone, death) and drives a square-wave tone sequence on a single output. Note lengths are counted in frame ticks, the same per-frame enable that paces input conditioning. It is the output-side counterpart to the button front end: clean internal events go in, a timed external waveform comes out.

---
 rtl/sfx_tone_gen_if.sv | 21 ++
 rtl/sfx_tone_gen.sv | 166 ++++++++++++++++
 tb/tb_sfx_tone_gen.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfx_tone_gen_if.sv
// Event/audio bundle between the game logic and the sound-effect generator.
// Game logic is the master; the tone generator is the slave.
interface sfx_tone_gen_if;
    logic frame_tick;
    logic jump_evt;
    logic score_evt;
    logic die_evt;
    logic mute;
    logic audio_out;
    logic busy;

    modport master (
        output frame_tick, jump_evt, score_evt, die_evt, mute,
        input  audio_out, busy
    );

    modport slave (
        input  frame_tick, jump_evt, score_evt, die_evt, mute,
        output audio_out, busy
    );
endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave sound-effect sequencer: jump, two-note score and death sounds.
// Define SFX_DIE_SWEEP_EN to make the death tone sweep downward in pitch.
module sfx_tone_gen #(
    parameter int PRESCALE       = 256,
    parameter int JUMP_HALF      = 48,
    parameter int SCORE_HALF_A   = 40,
    parameter int SCORE_HALF_B   = 30,
    parameter int DIE_HALF_START = 60,
    parameter int DIE_STEP       = 4,
    parameter int JUMP_FRAMES    = 4,
    parameter int SCORE_FRAMES   = 3,
    parameter int DIE_FRAMES     = 15
) (
    input logic         clk,
    input logic         reset,
    sfx_tone_gen_if.slave sfx
);

    typedef enum logic [2:0] {
        IDLE, JUMP, SCORE_A, SCORE_B, DIE
    } state_t;

    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

    state_t     state, state_nx;
    logic [7:0] presc, presc_nx;
    logic [7:0] half_cnt, half_cnt_nx;
    logic [7:0] half_period, half_period_nx;
    logic [3:0] frame_cnt, frame_cnt_nx;
    logic       sq, sq_nx;
    logic       audio_q, busy_q;

    logic       take_die, take_score, take_jump;
    logic       start;
    logic       tone_tick;
    logic [7:0] half_last;
    logic [3:0] note_len;
    logic [3:0] frame_inc;

    // An event wins only if it is at least as important as what is playing.
    always_comb begin
        take_die   = sfx.die_evt;
        take_score = sfx.score_evt && !sfx.die_evt && state != DIE;
        take_jump  = sfx.jump_evt && !sfx.die_evt && !sfx.score_evt
                     && (state == IDLE || state == JUMP);
    end

    always_comb begin
        note_len = 4'd0;
        case (state)
            JUMP:             note_len = 4'(JUMP_FRAMES);
            SCORE_A, SCORE_B: note_len = 4'(SCORE_FRAMES);
            DIE:              note_len = 4'(DIE_FRAMES);
            default:          note_len = 4'd0;
        endcase
    end

    assign tone_tick = (presc == PRE_MAX);
    assign half_last = (half_period == 8'd0) ? 8'd0 : half_period - 8'd1;
    assign frame_inc = frame_cnt + 4'd1;

`ifdef SFX_DIE_SWEEP_EN
    logic [8:0] sweep_sum;
    logic [7:0] sweep_hp;
    assign sweep_sum = {1'b0, half_period} + 9'(DIE_STEP);
    assign sweep_hp  = sweep_sum[8] ? 8'hFF : sweep_sum[7:0];
`endif

    always_comb begin
        state_nx       = state;
        presc_nx       = presc;
        half_cnt_nx    = half_cnt;
        half_period_nx = half_period;
        frame_cnt_nx   = frame_cnt;
        sq_nx          = sq;
        start          = 1'b0;

        unique case (1'b1)
            take_die: begin
                state_nx = DIE;
                start    = 1'b1;
            end
            take_score: begin
                state_nx = SCORE_A;
                start    = 1'b1;
            end
            take_jump: begin
                state_nx = JUMP;
                start    = 1'b1;
            end
            default: begin
                if (state != IDLE) begin
                    if (tone_tick) begin
                        presc_nx = 8'd0;
                        if (half_cnt == half_last) begin
                            half_cnt_nx = 8'd0;
                            sq_nx       = ~sq;
                        end else begin
                            half_cnt_nx = half_cnt + 8'd1;
                        end
                    end else begin
                        presc_nx = presc + 8'd1;
                    end

                    if (sfx.frame_tick) begin
                        if (frame_inc == note_len) begin
                            if (state == SCORE_A) begin
                                state_nx = SCORE_B;
                                start    = 1'b1;
                            end else begin
                                state_nx = IDLE;
                            end
                        end else begin
                            frame_cnt_nx = frame_inc;
`ifdef SFX_DIE_SWEEP_EN
                            if (state == DIE)
                                half_period_nx = sweep_hp;
`endif
                        end
                    end
                end
            end
        endcase

        // Any note start or return to idle wipes the tone counters.
        if (start || state_nx == IDLE) begin
            presc_nx     = 8'd0;
            half_cnt_nx  = 8'd0;
            frame_cnt_nx = 4'd0;
            sq_nx        = 1'b0;
            case (state_nx)
                JUMP:    half_period_nx = 8'(JUMP_HALF);
                SCORE_A: half_period_nx = 8'(SCORE_HALF_A);
                SCORE_B: half_period_nx = 8'(SCORE_HALF_B);
                DIE:     half_period_nx = 8'(DIE_HALF_START);
                default: half_period_nx = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= 8'd0;
            half_cnt    <= 8'd0;
            half_period <= 8'd0;
            frame_cnt   <= 4'd0;
            sq          <= 1'b0;
            audio_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            presc       <= presc_nx;
            half_cnt    <= half_cnt_nx;
            half_period <= half_period_nx;
            frame_cnt   <= frame_cnt_nx;
            sq          <= sq_nx;
            audio_q     <= sq_nx & ~sfx.mute;
            busy_q      <= (state_nx != IDLE);
        end
    end

    assign sfx.audio_out = audio_q;
    assign sfx.busy      = busy_q;

endmodule

// File: tb/tb_sfx_tone_gen.sv
// Bench for sfx_tone_gen: directed scenarios then random events,
// checked every cycle against a cycle-count reference model.
module tb_sfx_tone_gen;

    localparam int P      = 2;
    localparam int J_HALF = 3;
    localparam int SA     = 2;
    localparam int SB     = 1;
    localparam int D_HALF = 2;
    localparam int D_STEP = 1;
    localparam int J_FR   = 2;
    localparam int S_FR   = 1;
    localparam int D_FR   = 3;
    localparam int FRAME  = 40;
`ifdef SFX_DIE_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic clk;
    logic reset;
    sfx_tone_gen_if inf ();

    sfx_tone_gen #(
        .PRESCALE(P), .JUMP_HALF(J_HALF),
        .SCORE_HALF_A(SA), .SCORE_HALF_B(SB),
        .DIE_HALF_START(D_HALF), .DIE_STEP(D_STEP),
        .JUMP_FRAMES(J_FR), .SCORE_FRAMES(S_FR),
        .DIE_FRAMES(D_FR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sfx(inf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Sounds: 0 idle, 1 jump, 2 score note A, 3 score note B, 4 die.
    int m_snd;
    int m_hp;
    int m_since;
    int m_frames;
    bit m_sq;
    bit m_audio;
    bit m_busy;

    function automatic int pri_of(int s);
        case (s)
            1: return 1;
            2, 3: return 2;
            4: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int half_of(int s);
        case (s)
            1: return J_HALF;
            2: return SA;
            3: return SB;
            4: return D_HALF;
            default: return 0;
        endcase
    endfunction

    function automatic int len_of(int s);
        case (s)
            1: return J_FR;
            2, 3: return S_FR;
            4: return D_FR;
            default: return 0;
        endcase
    endfunction

    task automatic m_start(int s);
        m_snd = s; m_hp = half_of(s);
        m_since = 0; m_frames = 0; m_sq = 1'b0;
    endtask

    task automatic model_update(bit rst, bit fr, bit j, bit s, bit d, bit mu);
        int ev;
        int hpe;
        if (rst) begin
            m_start(0);
            m_audio = 1'b0; m_busy = 1'b0;
            return;
        end
        ev = d ? 4 : s ? 2 : j ? 1 : 0;
        if (ev != 0 && pri_of(ev) >= pri_of(m_snd)) begin
            m_start(ev);
        end else if (m_snd != 0) begin
            // Toggle once a full half-period worth of clocks has passed.
            m_since++;
            hpe = (m_hp == 0) ? 1 : m_hp;
            if (m_since == hpe * P) begin
                m_sq = ~m_sq; m_since = 0;
            end
            if (fr) begin
                m_frames++;
                if (m_frames == len_of(m_snd)) begin
                    if (m_snd == 2) m_start(3);
                    else m_start(0);
                end else if (SWEEP && m_snd == 4) begin
                    m_hp = (m_hp + D_STEP > 255) ? 255 : m_hp + D_STEP;
                end
            end
        end
        m_audio = m_sq & ~mu;
        m_busy = (m_snd != 0);
    endtask

    task automatic step();
        inf.frame_tick = (cyc % FRAME == FRAME - 1);
        @(posedge clk);
        model_update(reset, inf.frame_tick, inf.jump_evt,
                     inf.score_evt, inf.die_evt, inf.mute);
        cyc++;
        @(negedge clk);
        checks++;
        assert (inf.audio_out === m_audio) else begin
            errors++;
            $error("FAIL audio_out cyc=%0d got=%b exp=%b", cyc, inf.audio_out, m_audio);
        end
        checks++;
        assert (inf.busy === m_busy) else begin
            errors++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, inf.busy, m_busy);
        end
        inf.jump_evt = 1'b0;
        inf.score_evt = 1'b0;
        inf.die_evt = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Cycles from the current point until audio_out is first seen high.
    task automatic measure_rise(int expect_c, string tag);
        int k = 0;
        do begin
            step(); k++;
        end while (!inf.audio_out && k < 100);
        checks++;
        assert (k === expect_c) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, k, expect_c);
        end
    endtask

    task automatic measure_period(int expect_c, string tag);
        int k = 0;
        while (inf.audio_out && k < 100) begin step(); k++; end
        while (!inf.audio_out && k < 100) begin step(); k++; end
        checks++;
        assert (k === expect_c) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, k, expect_c);
        end
    endtask

    task automatic wait_idle(int bound, string tag);
        int k = 0;
        while (inf.busy && k < bound) begin step(); k++; end
        checks++;
        assert (k < bound) else begin
            errors++;
            $error("FAIL %s timeout got=%0d exp=<%0d", tag, k, bound);
        end
    endtask

    initial begin
        int r;
        int k;
        reset = 1'b1;
        inf.frame_tick = 1'b0;
        inf.jump_evt = 1'b0;
        inf.score_evt = 1'b0;
        inf.die_evt = 1'b0;
        inf.mute = 1'b0;
        m_start(0); m_audio = 1'b0; m_busy = 1'b0;
        @(negedge clk);
        steps(3);
        reset = 1'b0;
        checks++;
        assert (inf.audio_out === 1'b0 && inf.busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_state got=%b%b exp=00", inf.audio_out, inf.busy);
        end
        steps(100);

        // Jump: 6-cycle first rise, 12-cycle period.
        inf.jump_evt = 1'b1;
        step();
        measure_rise(6, "jump_first_rise");
        measure_period(12, "jump_period");
        wait_idle(200, "jump_end");
        steps(7);

        // Score, then death.
        inf.score_evt = 1'b1;
        step();
        measure_rise(4, "score_first_rise");
        measure_period(8, "score_period");
        wait_idle(200, "score_end");
        steps(11);
        inf.die_evt = 1'b1;
        step();
        measure_rise(4, "die_first_rise");
        wait_idle(300, "die_end");
        steps(5);

        // Jump and score together: score's 4-cycle rise wins.
        inf.jump_evt = 1'b1;
        inf.score_evt = 1'b1;
        step();
        measure_rise(4, "jump_score_pri");
        wait_idle(200, "pri_end");

        // Jump during death is dropped.
        inf.die_evt = 1'b1;
        step();
        steps(10);
        inf.jump_evt = 1'b1;
        step();
        checks++;
        assert (inf.busy === 1'b1) else begin
            errors++;
            $error("FAIL jump_in_die got=%b exp=1", inf.busy);
        end
        wait_idle(300, "die2_end");

        // Death during the second score note restarts with cleared counters.
        inf.score_evt = 1'b1;
        step();
        k = 0;
        while (m_snd != 3 && k < 200) begin step(); k++; end
        steps(3);
        inf.die_evt = 1'b1;
        step();
        measure_rise(4, "die_restart_rise");
        wait_idle(300, "die3_end");

        // Mute during jump.
        inf.jump_evt = 1'b1;
        step();
        steps(5);
        inf.mute = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            assert (inf.audio_out === 1'b0 && inf.busy === 1'b1) else begin
                errors++;
                $error("FAIL mute got=%b%b exp=01", inf.audio_out, inf.busy);
            end
        end
        inf.mute = 1'b0;
        wait_idle(200, "mute_end");

        // Reset mid-death, with a coincident event that must be ignored.
        inf.die_evt = 1'b1;
        step();
        steps(15);
        reset = 1'b1;
        inf.die_evt = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        assert (inf.audio_out === 1'b0 && inf.busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_mid_die got=%b%b exp=00", inf.audio_out, inf.busy);
        end
        step();
        checks++;
        assert (inf.busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_event_ignored got=%b exp=0", inf.busy);
        end

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 999);
            inf.jump_evt = (r < 30);
            inf.score_evt = (r >= 20 && r < 45);
            inf.die_evt = (r >= 40 && r < 52);
            if ($urandom_range(0, 99) < 2) inf.mute = ~inf.mute;
            reset = ($urandom_range(0, 999) < 2);
            step();
        end
        reset = 1'b0;
        inf.mute = 1'b0;
        steps(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
